acc_arbiter: RTL

ACC_ARBITER -- requirements
Module: acc_arbiter

---
 rtl/acc_arb_pkg.sv | 23 ++
 rtl/acc_arb_tag_fifo.sv | 50 +++++
 rtl/acc_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/acc_arb_pkg.sv
// Shared types and default sizing for the accumulator arbiter.
// Holds the FSM state type and a small cyclic-increment helper.
package acc_arb_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } acc_arb_state_e;

  localparam int DATA_WIDTH_DEF    = 32;
  localparam int NUM_REQ_DEF       = 4;
  localparam int REQ_WIDTH_DEF     = 2;
  localparam int ACC_CNT_DEF       = 4;
  localparam int ACC_CNT_WIDTH_DEF = 2;
  localparam int TAG_DEPTH_DEF     = 4;
  localparam int TAG_WIDTH_DEF     = 2;

  // Cyclic successor of idx in 0..n-1; works for non-power-of-two n.
  function automatic int next_idx(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/acc_arb_tag_fifo.sv
// Tag FIFO recording which requester owns each outstanding accumulation group.
// Zero-latency head; pushes while full and pops while empty are ignored.
module acc_arb_tag_fifo
  import acc_arb_pkg::*;
#(
  parameter int Depth      = TAG_DEPTH_DEF,
  parameter int PtrWidth   = TAG_WIDTH_DEF,
  parameter int EntryWidth = REQ_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  sclr_n,
  input  logic                  Push,
  input  logic [EntryWidth-1:0] PushData,
  input  logic                  Pop,
  output logic                  Full,
  output logic                  Empty,
  output logic [EntryWidth-1:0] Head
);

  logic [EntryWidth-1:0] mem [Depth];
  logic [PtrWidth-1:0]   wr_ptr;
  logic [PtrWidth-1:0]   rd_ptr;
  logic [PtrWidth:0]     count;
  logic                  do_push;
  logic                  do_pop;

  assign Full    = (count == (PtrWidth+1)'(Depth));
  assign Empty   = (count == '0);
  assign Head    = mem[rd_ptr];
  assign do_push = Push & ~Full;
  assign do_pop  = Pop & ~Empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= PushData;
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= PtrWidth'(next_idx(int'(wr_ptr), Depth));
      if (do_pop)  rd_ptr <= PtrWidth'(next_idx(int'(rd_ptr), Depth));
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/acc_arbiter.sv
// Grants one requester at a time an uninterrupted group of words into a shared accumulator
// and routes each group result back by tag. ACC_ARB_FIXED_PRIO_EN selects fixed priority.
// Grant 1 cycle after request, one idle bubble between groups; response path is combinational.
module acc_arbiter
  import acc_arb_pkg::*;
#(
  parameter int DataWidth            = DATA_WIDTH_DEF,
  parameter int NumReq               = NUM_REQ_DEF,
  parameter int ReqWidth             = REQ_WIDTH_DEF,
  parameter int AccumulateCount      = ACC_CNT_DEF,
  parameter int AccumulateCountWidth = ACC_CNT_WIDTH_DEF,
  parameter int TagDepth             = TAG_DEPTH_DEF,
  parameter int TagWidth             = TAG_WIDTH_DEF
) (
  input  logic                        clk,
  input  logic                        sclr_n,
  input  logic [NumReq-1:0]           ReqValid,
  input  logic [NumReq*DataWidth-1:0] ReqData,
  output logic [NumReq-1:0]           ReqRdy,
  output logic                        AccInValid,
  output logic [DataWidth-1:0]        AccInData,
  input  logic                        AccInRdy,
  input  logic                        AccOutValid,
  input  logic [DataWidth-1:0]        AccOutData,
  output logic                        AccOutRdy,
  output logic [NumReq-1:0]           RspValid,
  output logic [DataWidth-1:0]        RspData,
  input  logic [NumReq-1:0]           RspRdy,
  output logic [ReqWidth-1:0]         Grant,
  output logic                        Busy
);

  acc_arb_state_e                  state;
  logic [AccumulateCountWidth-1:0] burst_cnt;
  logic [ReqWidth-1:0]             arb_idx;
  logic                            arb_vld;
  logic                            tag_full;
  logic                            tag_empty;
  logic [ReqWidth-1:0]             tag_head;
  logic [DataWidth-1:0]            req_words [NumReq];
  logic                            in_burst;
  logic                            in_hs;
  logic                            last_word;
  logic                            grant_now;
  logic                            rsp_hs;

  for (genvar gi = 0; gi < NumReq; gi++) begin : g_words
    assign req_words[gi] = ReqData[gi*DataWidth +: DataWidth];
  end

`ifdef ACC_ARB_FIXED_PRIO_EN
  always_comb begin
    arb_idx = '0;
    arb_vld = 1'b0;
    for (int i = NumReq - 1; i >= 0; i--) begin
      if (ReqValid[i]) begin
        arb_idx = ReqWidth'(i);
        arb_vld = 1'b1;
      end
    end
  end
`else
  logic [ReqWidth-1:0] rr_ptr;

  // First valid requester at or after rr_ptr, cyclically.
  always_comb begin
    arb_idx = '0;
    arb_vld = 1'b0;
    for (int k = 0; k < NumReq; k++) begin
      if (!arb_vld && ReqValid[(int'(rr_ptr) + k) % NumReq]) begin
        arb_idx = ReqWidth'((int'(rr_ptr) + k) % NumReq);
        arb_vld = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!sclr_n)                 rr_ptr <= '0;
    else if (in_hs && last_word) rr_ptr <= ReqWidth'(next_idx(int'(Grant), NumReq));
  end
`endif

  // Gating with sclr_n keeps a reset mid-group from completing one more handshake.
  assign in_burst   = (state == BURST) & sclr_n;
  assign AccInValid = in_burst & ReqValid[Grant];
  assign AccInData  = req_words[Grant];
  assign in_hs      = AccInValid & AccInRdy;
  assign last_word  = (burst_cnt == AccumulateCountWidth'(AccumulateCount - 1));
  assign grant_now  = (state == IDLE) & arb_vld & ~tag_full;
  assign Busy       = (state == BURST);

  always_comb begin
    ReqRdy = '0;
    if (in_burst) ReqRdy[Grant] = AccInRdy;
  end

  always_ff @(posedge clk) begin
    if (!sclr_n) begin
      state     <= IDLE;
      burst_cnt <= '0;
      Grant     <= '0;
    end else if (state == IDLE) begin
      if (grant_now) begin
        state <= BURST;
        Grant <= arb_idx;
      end
    end else if (in_hs) begin
      if (last_word) begin
        burst_cnt <= '0;
        state     <= IDLE;
      end else begin
        burst_cnt <= burst_cnt + 1'b1;
      end
    end
  end

  // A result with no outstanding tag is never accepted nor forwarded.
  always_comb begin
    for (int i = 0; i < NumReq; i++) begin
      RspValid[i] = AccOutValid & ~tag_empty & (tag_head == ReqWidth'(i));
    end
  end

  assign AccOutRdy = ~tag_empty & RspRdy[tag_head];
  assign RspData   = AccOutData;
  assign rsp_hs    = AccOutValid & AccOutRdy;

  acc_arb_tag_fifo #(
    .Depth      (TagDepth),
    .PtrWidth   (TagWidth),
    .EntryWidth (ReqWidth)
  ) u_tag_fifo (
    .clk      (clk),
    .sclr_n   (sclr_n),
    .Push     (grant_now),
    .PushData (arb_idx),
    .Pop      (rsp_hs),
    .Full     (tag_full),
    .Empty    (tag_empty),
    .Head     (tag_head)
  );

endmodule
